// File: rtl/sbilinear_fetch.sv
// Request front end for sbilinear: fetches the four neighbour pixels of a
// fixed-point coordinate and derives power-of-two weight shifts for them.
module sbilinear_fetch #(
  parameter int DATA_W = 16,
  parameter int SHW    = 6,
  parameter int FRAC_W = 4,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int INT_W  = 8,
  localparam int ADDR_W = $clog2(IMG_W*IMG_H)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [INT_W+FRAC_W-1:0]   req_x,
  input  logic [INT_W+FRAC_W-1:0]   req_y,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic signed [DATA_W-1:0]  mem_rdata,
  output logic                      valid_out,
  output logic signed [DATA_W-1:0]  v00,
  output logic signed [DATA_W-1:0]  v01,
  output logic signed [DATA_W-1:0]  v10,
  output logic signed [DATA_W-1:0]  v11,
  output logic [SHW-1:0]            s0,
  output logic [SHW-1:0]            s1,
  output logic [SHW-1:0]            s2,
  output logic [SHW-1:0]            s3,
  output logic [2:0]                dbg_state
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int WW = 2*FRAC_W + 2;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high exactly while the FSM is idle.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_WAIT = 3'd5
  } state_t;

  state_t                    r_state;
  logic                      r_ready;
  logic                      r_mem_rd_en;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic                      r_valid;
  logic [XW-1:0]             r_x0, r_x1;
  logic [YW-1:0]             r_y0, r_y1;
  logic [FRAC_W-1:0]         r_fx, r_fy;
  logic signed [DATA_W-1:0]  r_c00, r_c01, r_c10;
  logic signed [DATA_W-1:0]  r_v00, r_v01, r_v10, r_v11;
  logic [SHW-1:0]            r_s0, r_s1, r_s2, r_s3;

  logic [INT_W-1:0]  w_xi, w_yi;
  logic              w_xclamp, w_yclamp;
  logic [XW-1:0]     w_x0, w_x1;
  logic [YW-1:0]     w_y0, w_y1;
  logic [FRAC_W-1:0] w_fx, w_fy;
  logic [FRAC_W:0]   w_wx0, w_wx1, w_wy0, w_wy1;
  logic [WW-1:0]     w_w00, w_w01, w_w10, w_w11;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [YW-1:0] y,
                                                input logic [XW-1:0] x);
    return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
  endfunction

  // Position of the highest set bit mapped to 2*FRAC_W - msb; zero weight gives 0.
  function automatic logic [SHW-1:0] shift_of(input logic [WW-1:0] w);
    logic [SHW-1:0] s;
    s = '0;
    for (int i = 0; i < WW; i++)
      if (w[i]) s = SHW'(2*FRAC_W - i);
    return s;
  endfunction

  // Clamp the incoming coordinate so the right/bottom neighbour stays in-image.
  always_comb begin
    w_xi     = req_x[INT_W+FRAC_W-1:FRAC_W];
    w_yi     = req_y[INT_W+FRAC_W-1:FRAC_W];
    w_xclamp = (w_xi >= INT_W'(IMG_W-1));
    w_yclamp = (w_yi >= INT_W'(IMG_H-1));
    w_x0     = w_xclamp ? XW'(IMG_W-1) : w_xi[XW-1:0];
    w_y0     = w_yclamp ? YW'(IMG_H-1) : w_yi[YW-1:0];
    w_fx     = w_xclamp ? '0 : req_x[FRAC_W-1:0];
    w_fy     = w_yclamp ? '0 : req_y[FRAC_W-1:0];
    w_x1     = (w_x0 == XW'(IMG_W-1)) ? w_x0 : w_x0 + XW'(1);
    w_y1     = (w_y0 == YW'(IMG_H-1)) ? w_y0 : w_y0 + YW'(1);
  end

  always_comb begin
    w_wx0 = (FRAC_W+1)'(2**FRAC_W) - {1'b0, r_fx};
    w_wx1 = {1'b0, r_fx};
    w_wy0 = (FRAC_W+1)'(2**FRAC_W) - {1'b0, r_fy};
    w_wy1 = {1'b0, r_fy};
    w_w00 = WW'(w_wx0) * WW'(w_wy0);
    w_w01 = WW'(w_wx1) * WW'(w_wy0);
    w_w10 = WW'(w_wx0) * WW'(w_wy1);
    w_w11 = WW'(w_wx1) * WW'(w_wy1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_valid     <= 1'b0;
      r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0;
      r_fx <= '0; r_fy <= '0;
      r_c00 <= '0; r_c01 <= '0; r_c10 <= '0;
      r_v00 <= '0; r_v01 <= '0; r_v10 <= '0; r_v11 <= '0;
      r_s0 <= '0; r_s1 <= '0; r_s2 <= '0; r_s3 <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_x0 <= w_x0; r_x1 <= w_x1; r_y0 <= w_y0; r_y1 <= w_y1;
            r_fx <= w_fx; r_fy <= w_fy;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= addr_of(w_y0, w_x0);
            r_ready     <= 1'b0;
            r_state     <= S_RD0;
          end
        end
        S_RD0: begin
          r_mem_addr <= addr_of(r_y0, r_x1);
          r_state    <= S_RD1;
        end
        S_RD1: begin
          r_c00      <= mem_rdata;
          r_mem_addr <= addr_of(r_y1, r_x0);
          r_state    <= S_RD2;
        end
        S_RD2: begin
          r_c01      <= mem_rdata;
          r_mem_addr <= addr_of(r_y1, r_x1);
          r_state    <= S_RD3;
        end
        S_RD3: begin
          r_c10       <= mem_rdata;
          r_mem_rd_en <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // Zero-weight neighbours are forced to 0 so sbilinear adds nothing.
          r_v00 <= (w_w00 == '0) ? '0 : r_c00;
          r_v01 <= (w_w01 == '0) ? '0 : r_c01;
          r_v10 <= (w_w10 == '0) ? '0 : r_c10;
          r_v11 <= (w_w11 == '0) ? '0 : mem_rdata;
          r_s0  <= shift_of(w_w00);
          r_s1  <= shift_of(w_w01);
          r_s2  <= shift_of(w_w10);
          r_s3  <= shift_of(w_w11);
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_rd_en <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign valid_out = r_valid;
  assign v00 = r_v00;
  assign v01 = r_v01;
  assign v10 = r_v10;
  assign v11 = r_v11;
  assign s0  = r_s0;
  assign s1  = r_s1;
  assign s2  = r_s2;
  assign s3  = r_s3;
  assign dbg_state = r_state;

endmodule
